// File: rtl/sim_memory_model_if_pkg.sv
// Shared helpers for the memory-model interface FIFO: count width and the
// bit layout of the internal status vector.
package sim_memory_model_if_pkg;

    function automatic int count_width(input int d_n);
        return d_n + 1;
    endfunction

    localparam int ST_EMPTY  = 0;
    localparam int ST_AEMPTY = 1;
    localparam int ST_AFULL  = 2;
    localparam int ST_FULL   = 3;
    localparam int ST_OVF    = 4;
    localparam int ST_UNF    = 5;
    localparam int ST_W      = 6;

endpackage

// File: rtl/sim_memory_model_if_fifo_ram.sv
// Storage array for the FIFO: registered write port, asynchronous read port.
// Contents are not reset; the pointers alone decide which entries are valid.
module sim_memory_model_if_fifo_ram #(
    parameter int N   = 16,
    parameter int D_N = 4
) (
    input  logic           clk,
    input  logic           we,
    input  logic [D_N-1:0] waddr,
    input  logic [N-1:0]   wdata,
    input  logic [D_N-1:0] raddr,
    output logic [N-1:0]   rdata
);

    logic [N-1:0] mem [2**D_N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sim_memory_model_if_sync_fifo_ex.sv
// Show-ahead single-clock FIFO with occupancy count, programmable almost
// flags, sticky overflow/underflow and a high-watermark counter.
module sim_memory_model_if_sync_fifo_ex
    import sim_memory_model_if_pkg::*;
#(
    parameter int N         = 16,
    parameter int D_N       = 4,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic         iCLOCK,
    input  logic         iRESET,
    input  logic         iREMOVE,
    input  logic         iWR_EN,
    input  logic [N-1:0] iWR_DATA,
    output logic         oWR_FULL,
    output logic         oWR_ALMOST_FULL,
    input  logic         iRD_EN,
    output logic [N-1:0] oRD_DATA,
    output logic         oRD_EMPTY,
    output logic         oRD_ALMOST_EMPTY,
    output logic [D_N:0] oCOUNT,
    output logic [D_N:0] oMAX_COUNT,
    input  logic         iERR_CLEAR,
    output logic         oOVERFLOW,
    output logic         oUNDERFLOW
);

    localparam int CW = count_width(D_N);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    generate
        if (DEPTH != (1 << D_N)) begin : g_bad_depth
            $error("DEPTH must equal 2**D_N");
        end
        if (AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_th
            $error("almost-full/almost-empty threshold out of range");
        end
    endgenerate

    logic [CW-1:0]   wp_q, rp_q, max_q;
    logic            ovf_q, unf_q;
    logic [CW-1:0]   count, next_count, next_max;
    logic            full, empty, wr_acc, rd_acc;
    logic [ST_W-1:0] status;

    // Handshake: iWR_EN is "valid" and ~oWR_FULL is "ready" for pushes;
    // iRD_EN is "valid" and ~oRD_EMPTY is "ready" for pops. A word moves on
    // an edge only when both halves hold on the pre-edge state; a request
    // without ready is dropped and recorded in the sticky error flag.
    assign count  = wp_q - rp_q;
    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign wr_acc = iWR_EN & ~full;
    assign rd_acc = iRD_EN & ~empty;

    assign next_count = count + CW'(wr_acc) - CW'(rd_acc);
    assign next_max   = (iERR_CLEAR || next_count > max_q) ? next_count : max_q;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wp_q  <= '0;
            rp_q  <= '0;
            max_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (iREMOVE) begin
            wp_q  <= '0;
            rp_q  <= '0;
            max_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wp_q  <= wp_q + CW'(wr_acc);
            rp_q  <= rp_q + CW'(rd_acc);
            max_q <= next_max;
            // A new error in the clearing cycle wins over the clear.
            ovf_q <= (ovf_q & ~iERR_CLEAR) | (iWR_EN & full);
            unf_q <= (unf_q & ~iERR_CLEAR) | (iRD_EN & empty);
        end
    end

    sim_memory_model_if_fifo_ram #(
        .N   (N),
        .D_N (D_N)
    ) u_ram (
        .clk   (iCLOCK),
        .we    (wr_acc & ~iREMOVE),
        .waddr (wp_q[D_N-1:0]),
        .wdata (iWR_DATA),
        .raddr (rp_q[D_N-1:0]),
        .rdata (oRD_DATA)
    );

    assign status[ST_EMPTY]  = empty;
    assign status[ST_AEMPTY] = (count <= AEMPTY_C);
    assign status[ST_AFULL]  = (count >= AFULL_C);
    assign status[ST_FULL]   = full;
    assign status[ST_OVF]    = ovf_q;
    assign status[ST_UNF]    = unf_q;

    assign oRD_EMPTY        = status[ST_EMPTY];
    assign oRD_ALMOST_EMPTY = status[ST_AEMPTY];
    assign oWR_ALMOST_FULL  = status[ST_AFULL];
    assign oWR_FULL         = status[ST_FULL];
    assign oOVERFLOW        = status[ST_OVF];
    assign oUNDERFLOW       = status[ST_UNF];
    assign oCOUNT           = count;
    assign oMAX_COUNT       = max_q;

endmodule

// File: tb/tb_sim_memory_model_if_sync_fifo_ex.sv
// Self-checking bench for the show-ahead FIFO against a queue-based model.
module tb_sim_memory_model_if_sync_fifo_ex;

    localparam int N = 16;
    localparam int DEPTH = 16;
    localparam int AFULL_TH = 14;
    localparam int AEMPTY_TH = 2;

    logic         iCLOCK = 1'b0;
    logic         iRESET = 1'b0;
    logic         iREMOVE = 1'b0;
    logic         iWR_EN = 1'b0;
    logic [N-1:0] iWR_DATA = '0;
    logic         iRD_EN = 1'b0;
    logic         iERR_CLEAR = 1'b0;
    logic         oWR_FULL, oWR_ALMOST_FULL, oRD_EMPTY, oRD_ALMOST_EMPTY;
    logic         oOVERFLOW, oUNDERFLOW;
    logic [N-1:0] oRD_DATA;
    logic [4:0]   oCOUNT, oMAX_COUNT;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    logic [N-1:0] exp_q[$];
    int           max_m = 0;
    logic         ovf_m = 1'b0;
    logic         unf_m = 1'b0;

    sim_memory_model_if_sync_fifo_ex dut (
        .iCLOCK           (iCLOCK),
        .iRESET           (iRESET),
        .iREMOVE          (iREMOVE),
        .iWR_EN           (iWR_EN),
        .iWR_DATA         (iWR_DATA),
        .oWR_FULL         (oWR_FULL),
        .oWR_ALMOST_FULL  (oWR_ALMOST_FULL),
        .iRD_EN           (iRD_EN),
        .oRD_DATA         (oRD_DATA),
        .oRD_EMPTY        (oRD_EMPTY),
        .oRD_ALMOST_EMPTY (oRD_ALMOST_EMPTY),
        .oCOUNT           (oCOUNT),
        .oMAX_COUNT       (oMAX_COUNT),
        .iERR_CLEAR       (iERR_CLEAR),
        .oOVERFLOW        (oOVERFLOW),
        .oUNDERFLOW       (oUNDERFLOW)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic model_reset();
        exp_q.delete();
        max_m = 0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [N-1:0] d, input logic rd,
                              input logic rm, input logic clr);
        bit was_full, was_empty;
        if (rm) begin
            model_reset();
        end else begin
            was_full  = (exp_q.size() == DEPTH);
            was_empty = (exp_q.size() == 0);
            if (rd && !was_empty) void'(exp_q.pop_front());
            if (wr && !was_full) exp_q.push_back(d);
            ovf_m = (clr ? 1'b0 : ovf_m) | (wr && was_full);
            unf_m = (clr ? 1'b0 : unf_m) | (rd && was_empty);
            if (clr || exp_q.size() > max_m) max_m = exp_q.size();
        end
    endtask

    // Drive one cycle from a falling edge, update the model at the rising
    // edge and return on the next falling edge, where outputs are sampled.
    task automatic cycle(input logic wr, input logic [N-1:0] d, input logic rd,
                         input logic rm, input logic clr);
        iWR_EN = wr; iWR_DATA = d; iRD_EN = rd; iREMOVE = rm; iERR_CLEAR = clr;
        @(posedge iCLOCK);
        model_step(wr, d, rd, rm, clr);
        @(negedge iCLOCK);
        iWR_EN = 1'b0; iRD_EN = 1'b0; iREMOVE = 1'b0; iERR_CLEAR = 1'b0;
    endtask

    task automatic test_reset();
        iRESET = 1'b1;
        repeat (2) @(negedge iCLOCK);
        iRESET = 1'b0;
        model_reset();
        @(negedge iCLOCK);
        n_checks++;
        if (oCOUNT !== 5'd0 || oRD_EMPTY !== 1'b1 || oWR_FULL !== 1'b0 ||
            oRD_ALMOST_EMPTY !== 1'b1 || oWR_ALMOST_FULL !== 1'b0 ||
            oMAX_COUNT !== 5'd0 || oOVERFLOW !== 1'b0 || oUNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b ae=%b af=%b max=%0d ovf=%b unf=%b, required 0 1 0 1 0 0 0 0",
                     oCOUNT, oRD_EMPTY, oWR_FULL, oRD_ALMOST_EMPTY, oWR_ALMOST_FULL,
                     oMAX_COUNT, oOVERFLOW, oUNDERFLOW);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (oCOUNT !== 5'(i + 1) || oRD_DATA !== 16'h1000 ||
                oWR_ALMOST_FULL !== (i + 1 >= AFULL_TH) || oWR_FULL !== (i + 1 == DEPTH) ||
                oMAX_COUNT !== 5'(i + 1) || oRD_ALMOST_EMPTY !== (i + 1 <= AEMPTY_TH)) begin
                n_fail++;
                $display("FAIL fill[%0d]: count=%0d data=%h af=%b full=%b max=%0d ae=%b, required count=%0d data=1000",
                         i, oCOUNT, oRD_DATA, oWR_ALMOST_FULL, oWR_FULL, oMAX_COUNT,
                         oRD_ALMOST_EMPTY, i + 1);
            end
        end
    endtask

    task automatic test_overflow_drain();
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (oOVERFLOW !== 1'b1 || oCOUNT !== 5'd16 || oRD_DATA !== 16'h1000) begin
            n_fail++;
            $display("FAIL overflow_push: ovf=%b count=%0d data=%h, required 1 16 1000",
                     oOVERFLOW, oCOUNT, oRD_DATA);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (oRD_DATA !== 16'h1000 + 16'(i) || oOVERFLOW !== 1'b1) begin
                n_fail++;
                $display("FAIL drain[%0d]: data=%h ovf=%b, required %h 1",
                         i, oRD_DATA, oOVERFLOW, 16'h1000 + 16'(i));
            end
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        n_checks++;
        if (oRD_EMPTY !== 1'b1 || oCOUNT !== 5'd0 || oUNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_end: empty=%b count=%0d unf=%b, required 1 0 0",
                     oRD_EMPTY, oCOUNT, oUNDERFLOW);
        end
    endtask

    task automatic test_underflow();
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (oUNDERFLOW !== 1'b1 || oCOUNT !== 5'd1 || oRD_DATA !== 16'hBEEF || oRD_EMPTY !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_push: unf=%b count=%0d data=%h empty=%b, required 1 1 beef 0",
                     oUNDERFLOW, oCOUNT, oRD_DATA, oRD_EMPTY);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if (oCOUNT !== 5'd3 || oRD_DATA !== exp_q[0] || oOVERFLOW !== 1'b0 || oUNDERFLOW !== 1'b0) begin
                n_fail++;
                $display("FAIL stream[%0d]: count=%0d data=%h ovf=%b unf=%b, required 3 %h 0 0",
                         i, oCOUNT, oRD_DATA, oOVERFLOW, oUNDERFLOW, exp_q[0]);
            end
            cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
        end
        n_checks++;
        if (oCOUNT !== 5'd3 || oRD_DATA !== exp_q[0] || oMAX_COUNT !== 5'(max_m)) begin
            n_fail++;
            $display("FAIL stream_end: count=%0d data=%h max=%0d, required 3 %h %0d",
                     oCOUNT, oRD_DATA, oMAX_COUNT, exp_q[0], max_m);
        end
    endtask

    task automatic test_remove_and_clear();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (oCOUNT !== 5'd0 || oMAX_COUNT !== 5'd0 || oRD_EMPTY !== 1'b1 ||
            oOVERFLOW !== 1'b0 || oUNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL remove: count=%0d max=%0d empty=%b ovf=%b unf=%b, required 0 0 1 0 0",
                     oCOUNT, oMAX_COUNT, oRD_EMPTY, oOVERFLOW, oUNDERFLOW);
        end
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h7777, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (oOVERFLOW !== 1'b1 || oCOUNT !== 5'd16 || oMAX_COUNT !== 5'd16 || oRD_DATA !== exp_q[0]) begin
            n_fail++;
            $display("FAIL clear_vs_overflow: ovf=%b count=%0d max=%0d data=%h, required 1 16 16 %h",
                     oOVERFLOW, oCOUNT, oMAX_COUNT, oRD_DATA, exp_q[0]);
        end
        // Clear with a pop: max reloads the post-edge count, overflow drops.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (oOVERFLOW !== 1'b0 || oMAX_COUNT !== 5'd15 || oCOUNT !== 5'd15) begin
            n_fail++;
            $display("FAIL clear_max: ovf=%b max=%0d count=%0d, required 0 15 15",
                     oOVERFLOW, oMAX_COUNT, oCOUNT);
        end
    endtask

    task automatic test_random();
        int wr_bias;
        for (int i = 0; i < 400; i++) begin
            wr_bias = ((i / 50) % 2 == 0) ? 75 : 25;
            cycle($urandom_range(0, 99) < wr_bias, 16'($urandom), $urandom_range(0, 99) < 50,
                  $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 3);
            n_checks++;
            if (oCOUNT !== 5'(exp_q.size()) || oMAX_COUNT !== 5'(max_m) ||
                oOVERFLOW !== ovf_m || oUNDERFLOW !== unf_m ||
                oRD_EMPTY !== (exp_q.size() == 0) || oWR_FULL !== (exp_q.size() == DEPTH) ||
                oWR_ALMOST_FULL !== (exp_q.size() >= AFULL_TH) ||
                oRD_ALMOST_EMPTY !== (exp_q.size() <= AEMPTY_TH) ||
                (exp_q.size() != 0 && oRD_DATA !== exp_q[0])) begin
                n_fail++;
                $display("FAIL random[%0d]: count=%0d max=%0d ovf=%b unf=%b data=%h, required count=%0d max=%0d ovf=%b unf=%b data=%h",
                         i, oCOUNT, oMAX_COUNT, oOVERFLOW, oUNDERFLOW, oRD_DATA, exp_q.size(),
                         max_m, ovf_m, unf_m, (exp_q.size() != 0) ? exp_q[0] : 16'h0);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (oCOUNT !== 5'd7 || oUNDERFLOW !== 1'b1 || oMAX_COUNT !== 5'd7) begin
            n_fail++;
            $display("FAIL pre_async_reset: count=%0d unf=%b max=%0d, required 7 1 7",
                     oCOUNT, oUNDERFLOW, oMAX_COUNT);
        end
        #2 iRESET = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (oCOUNT !== 5'd0 || oRD_EMPTY !== 1'b1 || oRD_ALMOST_EMPTY !== 1'b1 ||
            oWR_FULL !== 1'b0 || oMAX_COUNT !== 5'd0 || oUNDERFLOW !== 1'b0 || oOVERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: count=%0d empty=%b ae=%b full=%b max=%0d unf=%b ovf=%b, required 0 1 1 0 0 0 0",
                     oCOUNT, oRD_EMPTY, oRD_ALMOST_EMPTY, oWR_FULL, oMAX_COUNT, oUNDERFLOW, oOVERFLOW);
        end
        @(negedge iCLOCK);
        iRESET = 1'b0;
        cycle(1'b1, 16'h0123, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (oCOUNT !== 5'd1 || oRD_DATA !== 16'h0123 || oMAX_COUNT !== 5'd1) begin
            n_fail++;
            $display("FAIL post_reset_push: count=%0d data=%h max=%0d, required 1 0123 1",
                     oCOUNT, oRD_DATA, oMAX_COUNT);
        end
    endtask

    initial begin
        @(negedge iCLOCK);
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_back_to_back();
        test_remove_and_clear();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
